// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame/word widths and the default bit period.
package uart_pkg;

    localparam int unsigned UART_BITS            = 8;
    localparam int unsigned WORD_W               = 2 * UART_BITS;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    function automatic int unsigned half_bit(input int unsigned clks);
        return clks / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, ce-qualified bit timer and framing FSM.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 rx,
    output logic [UART_BITS-1:0] data_byte,
    output logic                 byte_done,
    output logic                 frame_err
);

    localparam int unsigned       TimerW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned       IdxW     = $clog2(UART_BITS);
    localparam logic [TimerW-1:0] BitLast  = TimerW'(CLKS_PER_BIT - 1);
    localparam logic [TimerW-1:0] HalfLast = TimerW'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [IdxW-1:0]   IdxLast  = IdxW'(UART_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;
    rx_state_e              state_q, state_d;
    logic [TimerW-1:0]      timer_q, timer_d;
    logic [IdxW-1:0]        bit_idx_q, bit_idx_d;
    logic [UART_BITS-1:0]   shift_q, shift_d;
    logic                   byte_done_q, byte_done_d;
    logic                   frame_err_q, frame_err_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    assign rx_s   = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TimerW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Re-check the line at mid start bit so short low glitches are rejected.
                if (timer_q == HalfLast) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (timer_q == BitLast) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[UART_BITS-1:1]};
                    if (bit_idx_q == IdxLast) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end
            end
            StStop: begin
                if (timer_q == BitLast) begin
                    timer_d = '0;
                    if (rx_s) begin
                        byte_done_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                // Hold off until the line returns high so a stuck-low rx does not re-trigger.
                timer_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                timer_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '1;
            state_q     <= StIdle;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (ce) begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_byte = shift_q;
    assign byte_done = byte_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/uart_word_rx.sv
// Pairs received UART bytes into 16-bit words (high byte first) behind a valid/ack handshake.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              rx,
    input  logic              resync,
    input  logic              word_ack,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic              byte_phase,
    output logic              frame_err,
    output logic              overrun
);

    logic [UART_BITS-1:0] rx_byte;
    logic                 rx_done;
    logic [UART_BITS-1:0] hi_q, hi_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic                 word_valid_q, word_valid_d;
    logic                 byte_phase_q, byte_phase_d;
    logic                 overrun_q, overrun_d;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx_byte (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .rx        (rx),
        .data_byte (rx_byte),
        .byte_done (rx_done),
        .frame_err (frame_err)
    );

    always_comb begin
        hi_d         = hi_q;
        word_d       = word_q;
        byte_phase_d = byte_phase_q;
        overrun_d    = 1'b0;
        // Ack is applied first so a coincident completion sees an empty slot.
        word_valid_d = word_valid_q & ~word_ack;
        if (rx_done && !resync) begin
            if (!byte_phase_q) begin
                hi_d         = rx_byte;
                byte_phase_d = 1'b1;
            end else begin
                byte_phase_d = 1'b0;
                if (!word_valid_d) begin
                    word_d       = {hi_q, rx_byte};
                    word_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
        if (resync) begin
            byte_phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q         <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            byte_phase_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (ce) begin
            hi_q         <= hi_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            byte_phase_q <= byte_phase_d;
            overrun_q    <= overrun_d;
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign byte_phase = byte_phase_q;
    assign overrun    = overrun_q;

endmodule
